// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan driver: FSM state encoding,
// channel field positions inside a {R,G,B} pixel word, and a width helper.
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_GHOST,
        ST_DISPLAY
    } scan_state_t;

    // Field position of each channel in a pixel word and on the rgb buses.
    localparam int unsigned CH_R = 2;
    localparam int unsigned CH_G = 1;
    localparam int unsigned CH_B = 0;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/hub75_plane_timer.sv
// Loadable down-counter that times the OE-active window of one bit plane
// (and, when enabled, the ghost-blanking gap). done marks the final cycle.
module hub75_plane_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 scan engine: shifts one BCM bit plane per pass, latches it and drives OE
// for BASE_ON<<plane cycles. Define HUB75_GHOST_BLANK_EN to blank GHOST cycles after each row change.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | panel blanked, waiting for en
// ST_SHIFT   | clocking COLS pixel pairs of the current plane onto the panel
// ST_LATCH   | one-cycle latch pulse, row address updated
// ST_GHOST   | extra blanking after a row change (plane 0 only, optional)
// ST_DISPLAY | OE active for BASE_ON<<plane cycles
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS    = 64,
    parameter int ADDR_W  = 4,
    parameter int BPP     = 4,
    parameter int DIV     = 2,
    parameter int BASE_ON = 32,
    parameter int GHOST   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    output logic [ADDR_W-1:0]        fb_row,
    output logic [$clog2(COLS)-1:0]  fb_col,
    input  logic [3*BPP-1:0]         fb_top,
    input  logic [3*BPP-1:0]         fb_bot,
    output logic [ADDR_W-1:0]        row_addr,
    output logic [2:0]               rgb0,
    output logic [2:0]               rgb1,
    output logic                     clk_shft,
    output logic                     lat,
    output logic                     oe,
    output logic                     frame_done
);

    localparam int CW = $clog2(COLS);
    localparam int KW = $clog2(2 * DIV);
    localparam int PW = clog2_min1(BPP);
    localparam int IW = $clog2(3 * BPP);
    localparam int TW = $clog2((BASE_ON << (BPP - 1)) + GHOST + 1) + 1;

    scan_state_t        state;
    logic [PW-1:0]      plane;
    logic [ADDR_W-1:0]  row;
    logic [CW-1:0]      col;
    logic [KW-1:0]      phase;

    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_done;

    logic [IW-1:0]      sel_r;
    logic [IW-1:0]      sel_g;
    logic [IW-1:0]      sel_b;
    logic               last_plane;
    logic               last_row;

    assign sel_r      = IW'(CH_R * BPP) + IW'(plane);
    assign sel_g      = IW'(CH_G * BPP) + IW'(plane);
    assign sel_b      = IW'(CH_B * BPP) + IW'(plane);
    assign last_plane = (plane == PW'(BPP - 1));
    assign last_row   = (row == '1);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TW'(BASE_ON) << plane;
        if (state == ST_LATCH) begin
            tmr_load = 1'b1;
`ifdef HUB75_GHOST_BLANK_EN
            if (plane == '0) begin
                tmr_val = TW'(GHOST);
            end
`endif
        end else if (state == ST_GHOST && tmr_done) begin
            tmr_load = 1'b1;
        end
    end

    hub75_plane_timer #(
        .W(TW)
    ) u_plane_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // fb_col runs one cycle ahead of the column being shifted so that the
    // framebuffer's one-cycle read latency lands on the first low cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            plane      <= '0;
            row        <= '0;
            col        <= '0;
            phase      <= '0;
            fb_row     <= '0;
            fb_col     <= '0;
            row_addr   <= '0;
            rgb0       <= '0;
            rgb1       <= '0;
            clk_shft   <= 1'b0;
            lat        <= 1'b0;
            oe         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    oe       <= 1'b1;
                    clk_shft <= 1'b0;
                    if (en) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    phase <= phase + 1'b1;
                    if (phase == '0) begin
                        rgb0 <= {fb_top[sel_r], fb_top[sel_g], fb_top[sel_b]};
                        rgb1 <= {fb_bot[sel_r], fb_bot[sel_g], fb_bot[sel_b]};
                    end
                    if (phase == KW'(DIV - 1)) begin
                        clk_shft <= 1'b1;
                    end
                    if (phase == KW'(2 * DIV - 2)) begin
                        fb_col <= fb_col + 1'b1;
                    end
                    if (phase == KW'(2 * DIV - 1)) begin
                        phase    <= '0;
                        clk_shft <= 1'b0;
                        col      <= col + 1'b1;
                        if (col == CW'(COLS - 1)) begin
                            state <= ST_LATCH;
                            lat   <= 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    lat      <= 1'b0;
                    row_addr <= row;
                    fb_row   <= last_plane ? row + 1'b1 : row;
`ifdef HUB75_GHOST_BLANK_EN
                    if (plane == '0) begin
                        state <= ST_GHOST;
                    end else begin
                        state <= ST_DISPLAY;
                        oe    <= 1'b0;
                    end
`else
                    state <= ST_DISPLAY;
                    oe    <= 1'b0;
`endif
                end
                ST_GHOST: begin
                    if (tmr_done) begin
                        state <= ST_DISPLAY;
                        oe    <= 1'b0;
                    end
                end
                ST_DISPLAY: begin
                    if (tmr_done) begin
                        oe <= 1'b1;
                        if (last_plane) begin
                            plane <= '0;
                            row   <= row + 1'b1;
                            if (last_row) begin
                                frame_done <= 1'b1;
                            end
                            state <= en ? ST_SHIFT : ST_IDLE;
                        end else begin
                            plane <= plane + 1'b1;
                            state <= ST_SHIFT;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Self-checking bench for hub75_scan_driver: random framebuffer contents, a
// pin monitor, and expectations derived from the scan order and BCM timing.
module tb_hub75_scan_driver;

    localparam int COLS    = 4;
    localparam int ADDR_W  = 1;
    localparam int BPP     = 2;
    localparam int DIV     = 2;
    localparam int BASE_ON = 3;
    localparam int GHOST   = 4;
    localparam int ROWS    = 1 << ADDR_W;
    localparam int CW      = $clog2(COLS);
`ifdef HUB75_GHOST_BLANK_EN
    localparam int GH = GHOST;
`else
    localparam int GH = 0;
`endif
    localparam int SHIFT_CYC = COLS * 2 * DIV;
    localparam int FRAME_CYC = ROWS * (BPP * (SHIFT_CYC + 1) + BASE_ON * ((1 << BPP) - 1) + GH);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en  = 1'b0;
    logic [ADDR_W-1:0]   fb_row;
    logic [CW-1:0]       fb_col;
    logic [3*BPP-1:0]    fb_top = '0;
    logic [3*BPP-1:0]    fb_bot = '0;
    logic [ADDR_W-1:0]   row_addr;
    logic [2:0]          rgb0;
    logic [2:0]          rgb1;
    logic                clk_shft;
    logic                lat;
    logic                oe;
    logic                frame_done;

    hub75_scan_driver #(
        .COLS(COLS), .ADDR_W(ADDR_W), .BPP(BPP), .DIV(DIV), .BASE_ON(BASE_ON), .GHOST(GHOST)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fb_row(fb_row), .fb_col(fb_col), .fb_top(fb_top), .fb_bot(fb_bot),
        .row_addr(row_addr), .rgb0(rgb0), .rgb1(rgb1),
        .clk_shft(clk_shft), .lat(lat), .oe(oe), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Framebuffer: rows 0..ROWS-1 are the top half, ROWS..2*ROWS-1 the bottom half.
    logic [3*BPP-1:0] pix [2*ROWS][COLS];

    always @(posedge clk) begin
        fb_top <= pix[int'(fb_row)][fb_col];
        fb_bot <= pix[int'(fb_row) + ROWS][fb_col];
    end

    typedef struct {
        int len;
        int row;
        int gap;
        int lat_lead;
    } run_t;

    run_t        runs[$];
    logic [5:0]  edges[$];
    int          fd_run[$];
    int          fd_cyc[$];
    int          cyc = 0, run_len = 0, gap_len = 0, lat_cyc = 0, lat_len = 0, lat_lead = 0, cur_row = 0;
    int          rgb_unstable = 0, lat_in_shft = 0, lat_wide = 0, fd_wide = 0;
    logic        prev_shft = 1'b0, prev_fd = 1'b0;
    logic [5:0]  prev_rgb = '0;
    int          n_pass = 0, n_total = 0;

    always @(negedge clk) begin
        cyc++;
        if (clk_shft === 1'b1 && prev_shft === 1'b0) begin
            edges.push_back({rgb0, rgb1});
            if ({rgb0, rgb1} !== prev_rgb) rgb_unstable++;
        end
        if (lat === 1'b1 && clk_shft === 1'b1) lat_in_shft++;
        if (lat === 1'b1) begin
            lat_len++;
            if (lat_len > 1) lat_wide++;
            lat_cyc = cyc;
        end else begin
            lat_len = 0;
        end
        if (oe === 1'b0) begin
            if (run_len == 0) lat_lead = cyc - lat_cyc;
            run_len++;
            cur_row = int'(row_addr);
        end else begin
            if (run_len > 0) begin
                runs.push_back('{run_len, cur_row, gap_len, lat_lead});
                gap_len = 0;
            end
            run_len = 0;
            gap_len++;
        end
        if (frame_done === 1'b1) begin
            fd_run.push_back(runs.size());
            fd_cyc.push_back(cyc);
            if (prev_fd === 1'b1) fd_wide++;
        end
        prev_shft = clk_shft;
        prev_rgb  = {rgb0, rgb1};
        prev_fd   = frame_done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clear_mon();
        runs.delete();
        edges.delete();
        fd_run.delete();
        fd_cyc.delete();
        gap_len = 0;
    endtask

    task automatic wait_runs(input int n, input int budget);
        int k;
        k = 0;
        while (runs.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_runs", 32'(runs.size() >= n), 1);
    endtask

    // Bit `pl` of each channel field of a {R,G,B} pixel word.
    function automatic logic [2:0] exp_rgb(input logic [3*BPP-1:0] v, input int pl);
        int val, r, g, b;
        val = int'(v);
        r = val / (1 << (2 * BPP));
        g = (val / (1 << BPP)) % (1 << BPP);
        b = val % (1 << BPP);
        return {((r >> pl) & 1) != 0, ((g >> pl) & 1) != 0, ((b >> pl) & 1) != 0};
    endfunction

    // Pass p of a scan starting at row sr covers row sr + p/BPP, plane p%BPP.
    task automatic check_passes(input int sr, input int np);
        for (int p = 0; p < np; p++) begin
            int row, pl, gh0, idx;
            run_t r;
            logic [5:0] e, x;
            row = (sr + p / BPP) % ROWS;
            pl  = p % BPP;
            gh0 = (pl == 0) ? GH : 0;
            if (p < runs.size()) begin
                r = runs[p];
                chk("oe_len", r.len, BASE_ON << pl);
                chk("row_addr", r.row, row);
                chk("lat_lead", r.lat_lead, 1 + gh0);
                if (p > 0) chk("blank_gap", r.gap, SHIFT_CYC + 1 + gh0);
            end
            for (int c = 0; c < COLS; c++) begin
                idx = p * COLS + c;
                if (idx < edges.size()) begin
                    e = edges[idx];
                    x = {exp_rgb(pix[row][c], pl), exp_rgb(pix[row + ROWS][c], pl)};
                    chk("rgb_at_shift", e, x);
                end
            end
        end
    endtask

    initial begin
        logic [5:0] e;
        int k;

        for (int r = 0; r < 2 * ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix[r][c] = 6'($urandom_range(0, 63));
        pix[0][0]    = {2'b10, 4'($urandom)};
        pix[ROWS][0] = {4'($urandom), 2'b01};

        // Reset values, held while en is raised.
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) tick();
        chk("rst_oe", oe, 1);
        chk("rst_lat", lat, 0);
        chk("rst_clk_shft", clk_shft, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_rgb0", rgb0, 0);
        chk("rst_rgb1", rgb1, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_fb_col", fb_col, 0);
        chk("rst_fb_row", fb_row, 0);
        en = 1'b1;
        repeat (5) tick();
        chk("rst_hold_oe", oe, 1);
        chk("rst_hold_edges", edges.size(), 0);
        en  = 1'b0;
        rst = 1'b1;
        repeat (5) tick();
        chk("idle_oe", oe, 1);
        chk("idle_edges", edges.size(), 0);

        // Two full frames plus one pass.
        clear_mon();
        en = 1'b1;
        wait_runs(2 * ROWS * BPP + 1, 2000);
        check_passes(0, 2 * ROWS * BPP + 1);
        if (edges.size() > COLS) begin
            e = edges[0];
            chk("map_p0_r0", e[5], 0);
            chk("map_p0_b1", e[0], 1);
            e = edges[COLS];
            chk("map_p1_r0", e[5], 1);
            chk("map_p1_b1", e[0], 0);
        end
        chk("frame_done_count", fd_run.size(), 2);
        if (fd_run.size() >= 2) begin
            chk("frame_done_pos0", fd_run[0], ROWS * BPP);
            chk("frame_done_pos1", fd_run[1], 2 * ROWS * BPP);
            chk("frame_period", fd_cyc[1] - fd_cyc[0], FRAME_CYC);
        end

        // en dropped during row 0 plane 0 shift.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_mon();
        en = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        wait_runs(BPP, 500);
        repeat (200) tick();
        chk("drop_runs", runs.size(), BPP);
        chk("drop_edges", edges.size(), BPP * COLS);
        chk("drop_idle_oe", oe, 1);
        chk("drop_idle_shft", clk_shft, 0);
        check_passes(0, BPP);
        clear_mon();
        en = 1'b1;
        wait_runs(1, 500);
        check_passes(1, 1);

        // Asynchronous reset while clk_shft is high.
        k = 0;
        while (clk_shft !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("rst_wait_shft", clk_shft, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_oe", oe, 1);
        chk("async_clk_shft", clk_shft, 0);
        chk("async_lat", lat, 0);
        chk("async_rgb0", rgb0, 0);
        chk("async_rgb1", rgb1, 0);
        chk("async_row_addr", row_addr, 0);
        chk("async_fb_row", fb_row, 0);
        chk("async_fb_col", fb_col, 0);
        chk("async_frame_done", frame_done, 0);
        tick();
        rst = 1'b1;
        clear_mon();
        wait_runs(ROWS * BPP, 2000);
        check_passes(0, ROWS * BPP);

        chk("rgb_stable_before_rise", rgb_unstable, 0);
        chk("lat_with_clk_shft", lat_in_shft, 0);
        chk("lat_width", lat_wide, 0);
        chk("frame_done_width", fd_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
# hub75_scan_driver

Parametrised HUB75 LED-matrix scan engine; successor to the fixed-size 1-bit panel driver inside the game top. Reads pixel pairs (top/bottom half) from a synchronous framebuffer port, shifts one bit plane per pass onto the panel and latches it. Drives row address, OE and LAT with binary-code modulation (BCM) for BPP-bit colour per channel. Sits between the game framebuffer and the panel pins in the top level.

## Interface
- COLS, 64, pixels per panel row (power of 2, ≥2)
- ADDR_W, 4, row-address lines (A..D); scan rows = 2^ADDR_W per half
- BPP, 4, bits per colour channel (1..8)
- DIV, 2, clk cycles per clk_shft half-period (≥2)
- BASE_ON, 32, OE-active clk cycles for bit plane 0
- GHOST, 4, blanking cycles after row change (used only with HUB75_GHOST_BLANK_EN)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- fb_row  out  ADDR_W  framebuffer row request (top half; bottom = fb_row + 2^ADDR_W)
- fb_col  out  $clog2(COLS)  framebuffer column request
- fb_top  in  3*BPP  top-half pixel {R,G,B}, MSB-first fields, valid 1 cycle after request
- fb_bot  in  3*BPP  bottom-half pixel, same format/latency
- row_addr  out  ADDR_W  panel {D,C,B,A}
- rgb0  out  3  {R0,G0,B0}
- rgb1  out  3  {R1,G1,B1}
- clk_shft  out  1  panel shift clock
- lat  out  1  panel latch, active-high
- oe  out  1  panel output enable, active-low (1 = blank)
- frame_done  out  1  one-cycle pulse at end of each frame

## Operation
- Reset values: row_addr 0, rgb0/rgb1 0, clk_shft 0, lat 0, oe 1, frame_done 0, fb_row 0, fb_col 0; state IDLE, plane 0, row 0.
- States: IDLE → SHIFT → LATCH → [GHOST] → DISPLAY → SHIFT (next plane/row) or IDLE.
- IDLE: oe=1, clk_shft=0. Leaves to SHIFT when en=1 sampled.
- SHIFT: for column c = 0..COLS-1: 2*DIV cycles; clk_shft=0 for first DIV cycles, 1 for last DIV. fb_col=c on first low cycle; on second low cycle rgb0/rgb1 take bit `plane` of each channel of fb_top/fb_bot. oe=1 throughout.
- LATCH: 1 cycle, lat=1, oe=1; row_addr ← current row.
- DISPLAY: oe=0 for BASE_ON << plane cycles; then plane+1, or if plane=BPP-1: plane 0, row+1.
- Row wrap: after last plane of row 2^ADDR_W-1, row → 0, frame_done=1 for one cycle (the cycle after DISPLAY ends).
- en=0 mid-frame: current row completes all planes, then IDLE with oe=1; next start at next row.
- rst asserted at any point: all outputs to reset values immediately (asynchronous), in-flight plane discarded.

## Timing
- Plane b cycles: COLS*2*DIV + 1 + (BASE_ON<<b) (+GHOST when b=0 and macro on).
- Frame cycles: 2^ADDR_W * Σb plane cycles.
- rgb stable ≥1 clk before every clk_shft rising edge; lat never high while clk_shft=1.
- DISPLAY counter width: ≥ $clog2(BASE_ON<<(BPP-1))+1; no overflow permitted.

## Configuration
- HUB75_GHOST_BLANK_EN defined: GHOST state of GHOST cycles, oe=1, inserted after LATCH on plane 0 (row change) to suppress ghosting. Undefined: LATCH goes straight to DISPLAY; GHOST parameter ignored.

## Structure
- Package hub75_pkg: state enum (IDLE, SHIFT, LATCH, GHOST, DISPLAY), channel field index constants R/G/B.
- One sub-module: hub75_plane_timer — loadable down-counter producing OE-active window of BASE_ON<<plane cycles with done pulse.

## Test plan
Params COLS=4, ADDR_W=1, BPP=2, DIV=2, BASE_ON=3, macro off unless stated.
- Reset: rst=0 → oe=1, lat=0, clk_shft=0, row_addr=0, rgb 0; held until release and en=1.
- Plane sequencing: en=1 → 4 clk_shft rising edges, lat high 1 cycle, oe=0 for 3 cycles (plane 0), then 4 edges, lat, oe=0 for 6 cycles (plane 1).
- Data mapping: fb_top R field 2'b10, fb_bot B field 2'b01 → rgb0[2]=0/rgb1[0]=1 in plane 0, rgb0[2]=1/rgb1[0]=0 in plane 1, sampled at clk_shft rise.
- Frame wrap: row_addr 0 then 1 then 0; frame_done pulses once per 86 cycles (2*((16+1+3)+(16+1+6))).
- en dropped during row 0 plane 0 SHIFT → row 0 plane 1 completes, then oe=1, clk_shft static 0; re-enable resumes at row 1.
- rst mid-SHIFT → outputs return to reset values same cycle; with HUB75_GHOST_BLANK_EN, plane 0 shows 4 extra oe=1 cycles between lat and oe=0; frame = 94 cycles.
